// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C master between NUM_REQ requesters.
// It forwards each requester's command and data to the master and reports done/err with a hang timeout.
module i2c_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [4*NUM_REQ-1:0] req_nbyte,
  input  logic [8*NUM_REQ-1:0] wr_data,
  output logic [NUM_REQ-1:0]   wr_ack,
  output logic [7:0]           rd_data,
  output logic [NUM_REQ-1:0]   rd_valid,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 mst_en,
  output logic [6:0]           mst_address,
  output logic                 mst_rw,
  output logic [3:0]           mst_n_byte,
  output logic [7:0]           mst_data_in,
  input  logic                 mst_byte_req,
  input  logic [7:0]           mst_data_out,
  input  logic                 mst_rd_valid,
  input  logic                 mst_done,
  input  logic                 mst_nack
);

  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StRun, StFinish} state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic [6:0]           addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [3:0]           nbyte_q, nbyte_d;
  logic [7:0]           din_q, din_d;
  logic                 en_q, en_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [TW-1:0]        to_q, to_d;
  logic                 ld_q, ld_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [NUM_REQ-1:0]   wack_q, wack_d;
  logic [NUM_REQ-1:0]   rdv_q, rdv_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [7:0]           rdata_q, rdata_d;

  logic [6:0]           addr_a  [NUM_REQ];
  logic [3:0]           nbyte_a [NUM_REQ];
  logic [7:0]           wr_a    [NUM_REQ];
  logic [NUM_REQ-1:0]   pending;
  logic                 grant_found;
  logic [OW-1:0]        grant_idx;
  logic [OW-1:0]        cand;
  logic                 cnt_inc;
  logic [3:0]           cnt_nxt;
  logic [NUM_REQ-1:0]   own_oh;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] i);
    return (i == OW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = req_addr[i*7 +: 7];
      nbyte_a[i] = req_nbyte[i*4 +: 4];
      wr_a[i]    = wr_data[i*8 +: 8];
    end
  end

  // A requester just handed req_ready may still hold req_valid for this cycle; skip it.
  assign pending = req_valid & ~ready_q;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = OW'((int'(rr_q) + k) % NUM_REQ);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    nbyte_d = nbyte_q;
    din_d   = din_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    ld_d    = |wack_q;
    ready_d = '0;
    wack_d  = '0;
    rdv_d   = '0;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cnt_inc = 1'b0;
    cnt_nxt = cnt_q;
    own_oh  = onehot(owner_q);

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          owner_d = grant_idx;
          addr_d  = addr_a[grant_idx];
          rw_d    = req_rw[grant_idx];
          nbyte_d = nbyte_a[grant_idx];
          din_d   = wr_a[grant_idx];
          ready_d = onehot(grant_idx);
          if (nbyte_a[grant_idx] == 4'd0) begin
            done_d = onehot(grant_idx);
            err_d  = onehot(grant_idx);
            rr_d   = next_ptr(grant_idx);
          end else begin
            state_d = StGrant;
          end
        end
      end
      StGrant: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        to_d    = '0;
        state_d = StRun;
      end
      StRun: begin
        if (!rw_q && mst_byte_req) begin
          cnt_inc = 1'b1;
          if (cnt_q < nbyte_q) wack_d = own_oh;
        end
        if (rw_q && mst_rd_valid) begin
          cnt_inc = 1'b1;
          rdata_d = mst_data_out;
          rdv_d   = own_oh;
        end
        if (cnt_inc && cnt_q != 4'hF) cnt_nxt = cnt_q + 4'd1;
        cnt_d = cnt_nxt;
        // Requester presents its next byte the cycle after wr_ack; pick it up then.
        if (ld_q) din_d = wr_a[owner_q];
        if (mst_byte_req || mst_rd_valid || mst_done) to_d = '0;
        else                                         to_d = to_q + TW'(1);
        if (mst_done) begin
          en_d    = 1'b0;
          done_d  = own_oh;
          err_d   = (mst_nack || cnt_nxt != nbyte_q) ? own_oh : '0;
          state_d = StFinish;
        end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          en_d    = 1'b0;
          done_d  = own_oh;
          err_d   = own_oh;
          state_d = StFinish;
        end
      end
      StFinish: begin
        en_d    = 1'b0;
        rr_d    = next_ptr(owner_q);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      nbyte_q <= '0;
      din_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      to_q    <= '0;
      ld_q    <= 1'b0;
      ready_q <= '0;
      wack_q  <= '0;
      rdv_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      nbyte_q <= nbyte_d;
      din_q   <= din_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ld_q    <= ld_d;
      ready_q <= ready_d;
      wack_q  <= wack_d;
      rdv_q   <= rdv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready   = ready_q;
  assign wr_ack      = wack_q;
  assign rd_valid    = rdv_q;
  assign rd_data     = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign mst_en      = en_q;
  assign mst_address = addr_q;
  assign mst_rw      = rw_q;
  assign mst_n_byte  = nbyte_q;
  assign mst_data_in = din_q;

endmodule
